// File: rtl/alu_dispatch_pkg.sv
// Shared types and constants for the ALU dispatch unit: FSM encoding, opcodes
// and the default field layout of the instruction word.
package alu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    DISPATCH = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam int OP_ADD = 1;
  localparam int OP_MUL = 2;

  localparam int DEF_DATA_SIZE      = 16;
  localparam int DEF_ID_SIZE        = 4;
  localparam int DEF_OPERATION_SIZE = 2;
  localparam int DEF_NUM_UNITS      = 2;
  localparam int DEF_CNT_SIZE       = 16;

  // Instruction word is {data1, data0, id, op}, op in the low bits.
  function automatic int fifo_in_width(input int data_size, input int id_size,
                                        input int op_size);
    return 2 * data_size + id_size + op_size;
  endfunction

endpackage

// File: rtl/alu_dispatch_decode.sv
// Opcode to one-hot unit select; unit k answers opcode OP_ADD+k, anything else
// (including 0) is illegal.
module alu_dispatch_decode
  import alu_dispatch_pkg::*;
#(
  parameter int OPERATION_SIZE = DEF_OPERATION_SIZE,
  parameter int NUM_UNITS      = DEF_NUM_UNITS
) (
  input  logic [OPERATION_SIZE-1:0] op,
  output logic [NUM_UNITS-1:0]      onehot,
  output logic                      legal
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      onehot[k] = (op == OPERATION_SIZE'(OP_ADD + k));
    end
  end

  assign legal = |onehot;

endmodule

// File: rtl/d_ff_async_en.sv
// Generic register with asynchronous active-low reset and synchronous load enable.
module d_ff_async_en #(
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/alu_dispatch_unit.sv
// Pops instruction words from the input FIFO and hands each to one ALU unit via
// valid/ready. Optional statistics counters: define ALU_DISPATCH_STATS_EN.
//
// Handshake: unit_valid[k] is held with stable op_a/op_b/id_out until the cycle
// in which unit_ready[k] is also high; that cycle is the transfer.
module alu_dispatch_unit
  import alu_dispatch_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int ID_SIZE        = DEF_ID_SIZE,
  parameter int OPERATION_SIZE = DEF_OPERATION_SIZE,
  parameter int NUM_UNITS      = DEF_NUM_UNITS,
  parameter int OPERATION_BIT  = 0,
  parameter int ID_BIT         = OPERATION_SIZE,
  parameter int DATA0_BIT      = OPERATION_SIZE + ID_SIZE,
  parameter int DATA1_BIT      = DATA0_BIT + DATA_SIZE,
  parameter int FIFO_IN_WIDTH  = fifo_in_width(DATA_SIZE, ID_SIZE, OPERATION_SIZE)
`ifdef ALU_DISPATCH_STATS_EN
  ,
  parameter int CNT_SIZE       = DEF_CNT_SIZE
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FIFO_IN_WIDTH-1:0] fifo_data,
  input  logic                     empty_in,
  output logic                     r_en_in,
  input  logic [NUM_UNITS-1:0]     unit_ready,
  output logic [NUM_UNITS-1:0]     unit_valid,
  output logic [DATA_SIZE-1:0]     op_a,
  output logic [DATA_SIZE-1:0]     op_b,
  output logic [DATA_SIZE/2-1:0]   op_a_half,
  output logic [DATA_SIZE/2-1:0]   op_b_half,
  output logic [ID_SIZE-1:0]       id_out,
  output logic                     busy,
  output logic                     err_op,
  output logic [1:0]               state_dbg
`ifdef ALU_DISPATCH_STATS_EN
  ,
  input  logic                            stats_clr,
  output logic [NUM_UNITS*CNT_SIZE-1:0]   disp_cnt,
  output logic [CNT_SIZE-1:0]             drop_cnt
`endif
);

  localparam int HOLD_W = 2 * DATA_SIZE + ID_SIZE + OPERATION_SIZE;

  state_e                    state_q, state_d;
  logic [1:0]                state_raw;
  logic                      load;
  logic                      handshake;
  logic [HOLD_W-1:0]         hold_d, hold_q;
  logic [OPERATION_SIZE-1:0] op_reg, dec_op;
  logic [NUM_UNITS-1:0]      dec_onehot;
  logic                      dec_legal;

  d_ff_async_en #(.WIDTH(2), .RST_VAL(2'(IDLE))) u_state_reg (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d), .q(state_raw)
  );
  assign state_q = state_e'(state_raw);

  assign hold_d = {fifo_data[DATA1_BIT +: DATA_SIZE], fifo_data[DATA0_BIT +: DATA_SIZE],
                   fifo_data[ID_BIT +: ID_SIZE], fifo_data[OPERATION_BIT +: OPERATION_SIZE]};

  d_ff_async_en #(.WIDTH(HOLD_W)) u_hold_reg (
    .clk(clk), .rst_n(rst_n), .en(load), .d(hold_d), .q(hold_q)
  );
  assign {op_b, op_a, id_out, op_reg} = hold_q;

  // One decoder serves both jobs: legality of the incoming word in FETCH and
  // the unit select of the held word in DISPATCH.
  assign dec_op = (state_q == FETCH) ? fifo_data[OPERATION_BIT +: OPERATION_SIZE] : op_reg;

  alu_dispatch_decode #(.OPERATION_SIZE(OPERATION_SIZE), .NUM_UNITS(NUM_UNITS)) u_decode (
    .op(dec_op), .onehot(dec_onehot), .legal(dec_legal)
  );

  assign unit_valid = (state_q == DISPATCH) ? dec_onehot : '0;
  assign handshake  = |(unit_valid & unit_ready);
  assign op_a_half  = op_a[DATA_SIZE/2-1:0];
  assign op_b_half  = op_b[DATA_SIZE/2-1:0];
  assign busy       = (state_q != IDLE);
  assign err_op     = (state_q == DROP);
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    r_en_in = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so the strobe is already low while reset is held.
        r_en_in = !empty_in && rst_n;
        if (r_en_in) state_d = FETCH;
      end
      FETCH: begin
        load    = 1'b1;
        state_d = dec_legal ? DISPATCH : DROP;
      end
      DISPATCH: begin
        if (handshake) begin
          r_en_in = !empty_in;
          state_d = empty_in ? IDLE : FETCH;
        end
      end
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_DISPATCH_STATS_EN
  // Saturating counters; a clear wins over a coincident increment.
  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_disp_cnt
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic                inc;
    assign inc   = unit_valid[k] & unit_ready[k];
    assign cnt_d = stats_clr ? '0 : cnt_q + CNT_SIZE'(1);
    d_ff_async_en #(.WIDTH(CNT_SIZE)) u_cnt (
      .clk(clk), .rst_n(rst_n), .en(stats_clr | (inc & ~&cnt_q)), .d(cnt_d), .q(cnt_q)
    );
    assign disp_cnt[k*CNT_SIZE +: CNT_SIZE] = cnt_q;
  end

  logic [CNT_SIZE-1:0] drop_d;
  logic                drop_inc;
  assign drop_inc = (state_q == DROP);
  assign drop_d   = stats_clr ? '0 : drop_cnt + CNT_SIZE'(1);
  d_ff_async_en #(.WIDTH(CNT_SIZE)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .en(stats_clr | (drop_inc & ~&drop_cnt)), .d(drop_d), .q(drop_cnt)
  );
`endif

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Self-checking bench for alu_dispatch_unit: FIFO model, transaction scoreboard
// and directed plus randomized scenarios.
module tb_alu_dispatch_unit;
  import alu_dispatch_pkg::*;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int OW = 2;
  localparam int NU = 2;
  localparam int HW = DW / 2;
  localparam int FW = 2 * DW + IW + OW;
  localparam int D0 = OW + IW;
  localparam int D1 = D0 + DW;
`ifdef ALU_DISPATCH_STATS_EN
  localparam int CW = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] fifo_data;
  logic          empty_in;
  logic          r_en_in;
  logic [NU-1:0] unit_ready, unit_valid;
  logic [DW-1:0] op_a, op_b;
  logic [HW-1:0] op_a_half, op_b_half;
  logic [IW-1:0] id_out;
  logic          busy, err_op;
  logic [1:0]    state_dbg;
`ifdef ALU_DISPATCH_STATS_EN
  logic             stats_clr;
  logic [NU*CW-1:0] disp_cnt;
  logic [CW-1:0]    drop_cnt;
  int               exp_disp[NU];
  int               exp_drop;
`endif

  alu_dispatch_unit #(
    .DATA_SIZE(DW), .ID_SIZE(IW), .OPERATION_SIZE(OW), .NUM_UNITS(NU)
`ifdef ALU_DISPATCH_STATS_EN
    , .CNT_SIZE(CW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .empty_in(empty_in),
    .r_en_in(r_en_in), .unit_ready(unit_ready), .unit_valid(unit_valid),
    .op_a(op_a), .op_b(op_b), .op_a_half(op_a_half), .op_b_half(op_b_half),
    .id_out(id_out), .busy(busy), .err_op(err_op), .state_dbg(state_dbg)
`ifdef ALU_DISPATCH_STATS_EN
    , .stats_clr(stats_clr), .disp_cnt(disp_cnt), .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] exp_q[$];
  int            ren_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            inflight = 0;
  int            last_ren = -100;
  bit            pending = 1'b0;

  int            s_cyc;
  logic          s_ren, s_hs, s_err, s_busy;
  logic [NU-1:0] s_uv;
  logic [DW-1:0] s_a, s_b;
  logic [HW-1:0] s_ah;
  logic [IW-1:0] s_id;

  function automatic logic [FW-1:0] mk(input int op, input int id, input int d0, input int d1);
    return {DW'(d1), DW'(d0), IW'(id), OW'(op)};
  endfunction

  function automatic bit all_done();
    return exp_q.size() == 0 && fifo_q.size() == 0 && inflight == 0;
  endfunction

  task automatic push(input logic [FW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    ren_q.delete();
    inflight = 0;
    last_ren = -100;
    pending  = 1'b0;
`ifdef ALU_DISPATCH_STATS_EN
    for (int k = 0; k < NU; k++) exp_disp[k] = 0;
    exp_drop = 0;
`endif
  endtask

  // One clock cycle: inputs settle from the negedge, outputs are sampled 1 time
  // unit later and checked against the transaction model, then the FIFO pops.
  task automatic step();
    logic          hs;
    logic [FW-1:0] w;
    int            op;
    empty_in = (fifo_q.size() == 0);
    #1;
    hs    = |(unit_valid & unit_ready);
    s_cyc = cyc; s_ren = r_en_in; s_uv = unit_valid; s_a = op_a; s_b = op_b;
    s_ah  = op_a_half; s_id = id_out; s_busy = busy; s_err = err_op; s_hs = hs;

    n_cmp++;
    if (r_en_in && empty_in) begin
      n_err++;
      $display("FAIL ren_while_empty: cycle %0d r_en_in=%b required 0", cyc, r_en_in);
    end
    n_cmp++;
    if (busy !== (inflight > 0)) begin
      n_err++;
      $display("FAIL busy: cycle %0d got %b required %b", cyc, busy, inflight > 0);
    end
    n_cmp++;
    if ($countones(unit_valid) > 1 || (err_op && unit_valid != '0)) begin
      n_err++;
      $display("FAIL valid_onehot: cycle %0d unit_valid=%b err_op=%b", cyc, unit_valid, err_op);
    end
    if (r_en_in) begin
      n_cmp++;
      if (cyc - last_ren < 2 || (unit_valid != '0 && !hs)) begin
        n_err++;
        $display("FAIL ren_timing: cycle %0d previous strobe %0d unit_valid=%b", cyc, last_ren, unit_valid);
      end
      ren_q.push_back(cyc);
      last_ren = cyc;
    end
    if ((unit_valid != '0 && !pending) || err_op) begin
      n_cmp++;
      if (ren_q.size() == 0 || cyc != ren_q[0] + 2) begin
        n_err++;
        $display("FAIL latency: result at cycle %0d, required strobe cycle + 2 (strobes queued %0d)",
                 cyc, ren_q.size());
      end
      if (ren_q.size() != 0) void'(ren_q.pop_front());
    end
    if (unit_valid != '0 || err_op) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: cycle %0d unit_valid=%b err_op=%b", cyc, unit_valid, err_op);
      end else begin
        w  = exp_q[0];
        op = int'(w[OW-1:0]);
        if (err_op) begin
          if (op >= 1 && op <= NU) begin
            n_err++;
            $display("FAIL drop_of_legal: cycle %0d op=%0d dropped", cyc, op);
          end
        end else if (!(op >= 1 && op <= NU) || unit_valid !== NU'(1 << (op - 1)) ||
                     op_a !== w[D0 +: DW] || op_b !== w[D1 +: DW] || op_a_half !== w[D0 +: HW] ||
                     op_b_half !== w[D1 +: HW] || id_out !== w[OW +: IW]) begin
          n_err++;
          $display("FAIL dispatch_fields: cycle %0d got v=%b a=%h b=%h ah=%h bh=%h id=%h required op=%0d a=%h b=%h id=%h",
                   cyc, unit_valid, op_a, op_b, op_a_half, op_b_half, id_out, op,
                   w[D0 +: DW], w[D1 +: DW], w[OW +: IW]);
        end
        if (hs || err_op) void'(exp_q.pop_front());
      end
      if (hs || err_op) inflight--;
    end
`ifdef ALU_DISPATCH_STATS_EN
    for (int k = 0; k < NU; k++) begin
      n_cmp++;
      if (disp_cnt[k*CW +: CW] !== CW'(exp_disp[k])) begin
        n_err++;
        $display("FAIL disp_cnt[%0d]: cycle %0d got %0d required %0d", k, cyc, disp_cnt[k*CW +: CW], exp_disp[k]);
      end
    end
    n_cmp++;
    if (drop_cnt !== CW'(exp_drop)) begin
      n_err++;
      $display("FAIL drop_cnt: cycle %0d got %0d required %0d", cyc, drop_cnt, exp_drop);
    end
    if (stats_clr) begin
      for (int k = 0; k < NU; k++) exp_disp[k] = 0;
      exp_drop = 0;
    end else begin
      for (int k = 0; k < NU; k++)
        if (unit_valid[k] && unit_ready[k] && exp_disp[k] < (1 << CW) - 1) exp_disp[k]++;
      if (err_op && exp_drop < (1 << CW) - 1) exp_drop++;
    end
`endif
    pending = (unit_valid != '0) && !hs;
    if (r_en_in) inflight++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (s_ren && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (!all_done()) begin
      n_err++;
      $display("FAIL %s_timeout: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; empty_in = 1'b0; unit_ready = '0; fifo_data = '0;
`ifdef ALU_DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    clear_model();
    #1;
    n_cmp++;
    if ({r_en_in, unit_valid, op_a, op_b, id_out, busy, err_op, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL reset_values: ren=%b v=%b a=%h b=%h id=%h busy=%b err=%b st=%0d required all 0",
               r_en_in, unit_valid, op_a, op_b, id_out, busy, err_op, state_dbg);
    end
    empty_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_single_add();
    int t_ren = -1;
    unit_ready = 2'b01;
    push(mk(OP_ADD, 2, 16'h0005, 16'h0003));
    for (int i = 0; i < 10 && t_ren < 0; i++) begin
      step();
      if (s_ren) t_ren = s_cyc;
    end
    n_cmp++;
    if (t_ren < 0) begin
      n_err++;
      $display("FAIL add_no_strobe: r_en_in=0 for 10 cycles, required a pulse");
    end
    step();
    step();
    n_cmp++;
    if (s_uv !== 2'b01 || s_a !== 16'h0005 || s_b !== 16'h0003 || s_id !== 4'h2) begin
      n_err++;
      $display("FAIL add_present: got v=%b a=%h b=%h id=%h required v=01 a=0005 b=0003 id=2", s_uv, s_a, s_b, s_id);
    end
    step();
    n_cmp++;
    if (s_uv !== 2'b00) begin
      n_err++;
      $display("FAIL add_valid_drop: got %b required 00", s_uv);
    end
    wait_done("add", 20);
  endtask

  task automatic test_mul_stall();
    int n = 0;
    unit_ready = 2'b01;
    push(mk(OP_MUL, 9, 16'h12AB, 16'h0777));
    push(mk(OP_ADD, 10, 16'h0001, 16'h0002));
    step();
    while (s_uv == '0 && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_cmp++;
      if (s_uv !== 2'b10 || s_ah !== 8'hAB || s_ren !== 1'b0) begin
        n_err++;
        $display("FAIL mul_stall[%0d]: got v=%b ah=%h ren=%b required v=10 ah=ab ren=0", i, s_uv, s_ah, s_ren);
      end
    end
    unit_ready = 2'b11;
    wait_done("mul_stall", 30);
  endtask

  task automatic test_back_to_back();
    int ren_cycles[$];
    int hs_ids[$];
    int n = 0;
    unit_ready = 2'b11;
    for (int i = 1; i <= 4; i++) push(mk((i % 2) + 1, i, 16'h1000 + i, 16'h2000 + i));
    while (!all_done() && n < 40) begin
      step();
      if (s_ren) ren_cycles.push_back(s_cyc);
      if (s_hs) hs_ids.push_back(int'(s_id));
      n++;
    end
    n_cmp++;
    if (ren_cycles.size() != 4 || hs_ids.size() != 4) begin
      n_err++;
      $display("FAIL b2b_counts: strobes=%0d handshakes=%0d required 4 and 4", ren_cycles.size(), hs_ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (hs_ids[i] != i + 1 || (i > 0 && ren_cycles[i] - ren_cycles[i-1] != 2)) begin
          n_err++;
          $display("FAIL b2b_order[%0d]: id=%0d required %0d, strobe spacing %0d required 2", i, hs_ids[i], i + 1,
                   i > 0 ? ren_cycles[i] - ren_cycles[i-1] : 2);
        end
      end
    end
  endtask

  task automatic test_illegal_op();
    int errs = 0, hss = 0, hs_id = -1, n = 0;
    unit_ready = 2'b11;
    push(mk(0, 5, 16'hDEAD, 16'hBEEF));
    push(mk(3, 6, 16'hCAFE, 16'hF00D));
    push(mk(OP_ADD, 7, 16'h0011, 16'h0022));
    while (!all_done() && n < 40) begin
      step();
      if (s_err) errs++;
      if (s_hs) begin hss++; hs_id = int'(s_id); end
      n++;
    end
    n_cmp++;
    if (errs != 2 || hss != 1 || hs_id != 7) begin
      n_err++;
      $display("FAIL illegal_op: err pulses=%0d handshakes=%0d id=%0d required 2, 1, 7", errs, hss, hs_id);
    end
  endtask

  task automatic test_reset_mid_dispatch();
    int n = 0;
    unit_ready = 2'b00;
    push(mk(OP_ADD, 3, 16'h0ABC, 16'h0DEF));
    step();
    while (s_uv == '0 && n < 10) begin
      step();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({r_en_in, unit_valid, op_a, op_b, id_out, busy, err_op} !== '0) begin
      n_err++;
      $display("FAIL async_reset: ren=%b v=%b a=%h b=%h id=%h busy=%b err=%b required all 0",
               r_en_in, unit_valid, op_a, op_b, id_out, busy, err_op);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (s_ren !== 1'b0 || s_busy !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle: ren=%b busy=%b required 0 0", s_ren, s_busy);
      end
    end
    unit_ready = 2'b01;
    push(mk(OP_ADD, 4, 16'h0100, 16'h0200));
    wait_done("post_reset", 20);
  endtask

  task automatic test_random();
    int pushed = 0, n = 0;
    while ((pushed < 60 || !all_done()) && n < 3000) begin
      if (pushed < 60 && $urandom_range(0, 2) != 0) begin
        push(mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 65535)));
        pushed++;
      end
      unit_ready = NU'($urandom_range(0, 3));
      step();
      n++;
    end
    n_cmp++;
    if (!all_done()) begin
      n_err++;
      $display("FAIL random_timeout: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

`ifdef ALU_DISPATCH_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    unit_ready = 2'b01;
    for (int i = 0; i < 5; i++) push(mk(OP_ADD, i, i, i));
    wait_done("stats", 60);
    n_cmp++;
    if (disp_cnt[CW-1:0] !== 2'd3) begin
      n_err++;
      $display("FAIL stats_saturate: disp_cnt[0]=%0d required 3", disp_cnt[CW-1:0]);
    end
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    n_cmp++;
    if (disp_cnt !== '0 || drop_cnt !== '0) begin
      n_err++;
      $display("FAIL stats_clear: disp_cnt=%h drop_cnt=%0d required 0", disp_cnt, drop_cnt);
    end
    push(mk(OP_ADD, 1, 1, 1));
    while (!all_done() && s_cyc < cyc + 20) begin
      stats_clr = ($urandom_range(0, 1) == 1);
      step();
    end
    stats_clr = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_mul_stall();
    test_back_to_back();
    test_illegal_op();
    test_reset_mid_dispatch();
    test_random();
`ifdef ALU_DISPATCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_dispatch_unit.md
Name: alu_dispatch_unit

Overview:
Parametrised successor to the ALU input controller. It pops one instruction word {data1, data0, id, op} from the input FIFO and decodes the opcode to one of NUM_UNITS ALU execution units. It presents the operands and ID on shared buses and holds a per-unit valid until that unit accepts it with a valid/ready handshake. It sits between FIFO_IN and the ALU units, and drops illegal opcodes with an error pulse.

Parameters:
DATA_SIZE, 16, operand width; half-width units use the low DATA_SIZE/2 bits
ID_SIZE, 4, transaction ID width
OPERATION_SIZE, 2, opcode field width
NUM_UNITS, 2, number of execution units; unit k is selected by opcode k+1 (1=ADD, 2=MUL by default)
OPERATION_BIT, 0, lowest bit of the opcode field in fifo_data
ID_BIT, OPERATION_SIZE, lowest bit of the ID field
DATA0_BIT, OPERATION_SIZE+ID_SIZE, lowest bit of data0
DATA1_BIT, DATA0_BIT+DATA_SIZE, lowest bit of data1
FIFO_IN_WIDTH, 2*DATA_SIZE+ID_SIZE+OPERATION_SIZE, input word width
CNT_SIZE, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fifo_data  in  FIFO_IN_WIDTH  FIFO read data, valid one cycle after r_en_in
empty_in  in  1  FIFO empty flag
r_en_in  out  1  FIFO read strobe, single-cycle pulse per pop
unit_ready  in  NUM_UNITS  per-unit ready
unit_valid  out  NUM_UNITS  per-unit valid, at most one bit set
op_a  out  DATA_SIZE  data0 operand
op_b  out  DATA_SIZE  data1 operand
op_a_half  out  DATA_SIZE/2  op_a[DATA_SIZE/2-1:0]
op_b_half  out  DATA_SIZE/2  op_b[DATA_SIZE/2-1:0]
id_out  out  ID_SIZE  transaction ID
busy  out  1  high in any state other than IDLE
err_op  out  1  one-cycle pulse when an illegal opcode is dropped

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; r_en_in, unit_valid, op_a, op_b, id_out, busy and err_op are all 0.
- States are IDLE, FETCH, DISPATCH and DROP.
- IDLE: r_en_in = !empty_in (combinational). If r_en_in=1, go to FETCH; otherwise stay in IDLE.
- FETCH:
  - Capture fifo_data fields into the holding registers (op_a, op_b, id_out, op_reg).
  - Decode op. If 1 <= op <= NUM_UNITS, go to DISPATCH; otherwise go to DROP.
- DISPATCH:
  - unit_valid[op_reg-1]=1; the outputs stay stable until the handshake.
  - Handshake: unit_valid[k] & unit_ready[k] in the same cycle.
  - On handshake with !empty_in: r_en_in=1 in that cycle and go to FETCH (back-to-back).
  - On handshake with empty_in: go to IDLE.
  - Without handshake: stay in DISPATCH. Readiness of other units is ignored.
- DROP: err_op=1 for one cycle, then go to IDLE. No unit_valid is raised.
- Throughput is one instruction per 2 cycles when the units are always ready. Latency from r_en_in to unit_valid is 2 cycles.
- r_en_in is never asserted while empty_in=1, and never in FETCH or DROP. It never asserts twice without an intervening FETCH.
- The holding registers load only in FETCH; op_a, op_b and id_out keep their last value otherwise.
- If unit_ready rises before unit_valid, the handshake occurs in the first DISPATCH cycle.
- A reset asserted mid-DISPATCH drops the pending instruction; there is no replay.

Optional Feature:
ALU_DISPATCH_STATS_EN:
- Defined: adds outputs disp_cnt (NUM_UNITS*CNT_SIZE, one counter per unit, incremented on that unit's handshake) and drop_cnt (CNT_SIZE, incremented in DROP).
- Counters saturate at all-ones, reset to 0, and clear synchronously on the added input stats_clr (1 bit). If clear and increment coincide, the counter result is 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_dispatch_pkg holds:
  - the state encoding (IDLE=0, FETCH=1, DISPATCH=2, DROP=3);
  - the opcode constants OP_ADD=1 and OP_MUL=2;
  - the field-offset default expressions.
- Registers use the existing d_ff_async_en flop.
- One sub-module is natural: alu_dispatch_decode, a combinational opcode-to-one-hot decoder with a legal flag, reused by the output controller.

Test Plan:
- Single ADD: word {data1=0x0003, data0=0x0005, id=0x2, op=1}, empty_in falls, unit_ready=2'b01 -> one r_en_in pulse; 2 cycles later unit_valid=2'b01, op_a=0x0005, op_b=0x0003, id_out=2; valid drops the cycle after the handshake.
- MUL with backpressure: op=2, data0=0x12AB, unit_ready[1]=0 for 5 cycles -> unit_valid=2'b10 and op_a_half=0xAB held stable for all 5 cycles; no r_en_in during the stall.
- Back-to-back: 4 queued words, units always ready -> r_en_in pulses every 2 cycles; 4 handshakes in order, each with the matching id.
- Illegal opcode: op=0, then op=3 -> err_op pulses twice, unit_valid stays 0, and the next legal word dispatches normally.
- Reset mid-DISPATCH: rst_n=0 while unit_valid=2'b01 -> all outputs read 0 immediately (asynchronous); after release the block sits in IDLE until empty_in=0.
- With ALU_DISPATCH_STATS_EN and CNT_SIZE=2: 5 ADD handshakes -> disp_cnt[0] saturates at 3; pulsing stats_clr -> 0.
